// File: rtl/icache_axi_refill_engine.sv
// AXI read-channel refill engine for an instruction cache: one outstanding line or word fetch.
// Optional feature: define ICACHE_REFILL_ERR_EN to report AXI read errors on rtrn_err_o.
module icache_axi_refill_engine #(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned PlenWidth    = 56,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiRdId      = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    kill_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PlenWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [PlenWidth-1:0]    ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic                    r_last_i,
  input  logic [1:0]              r_resp_i,
  output logic                    rtrn_vld_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    busy_o
);

  localparam int unsigned Beats   = LineWidth / AxiDataWidth;
  localparam int unsigned WordOff = $clog2(AxiDataWidth / 8);
  localparam int unsigned LineOff = $clog2(LineWidth / 8);
  localparam int unsigned SliceW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW    = $clog2(Beats + 1);

  localparam logic [PlenWidth-1:0]  LineMask = {{(PlenWidth-LineOff){1'b1}}, {LineOff{1'b0}}};
  localparam logic [PlenWidth-1:0]  WordMask = {{(PlenWidth-WordOff){1'b1}}, {WordOff{1'b0}}};
  localparam logic [7:0]            LenLine  = 8'(Beats - 1);
  localparam logic [2:0]            SizeW    = 3'(WordOff);
  localparam logic [AxiIdWidth-1:0] ArId     = AxiIdWidth'(AxiRdId);
  localparam logic [CntW-1:0]       CntMax   = CntW'(Beats);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RTRN} state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [CntW-1:0]        r_cnt;
  logic [LineWidth-1:0]   r_line;
  logic [PlenWidth-1:0]   r_paddr;
  logic                   r_nc;
  logic [TidWidth-1:0]    r_tid;
  logic                   r_kill;
  logic [SliceW-1:0]      w_nc_slice;
  logic [SliceW-1:0]      w_wr_slice;
  logic                   w_wr_en;
  logic                   w_rtrn;

  if (Beats > 1) begin : g_nc_slice
    assign w_nc_slice = r_paddr[LineOff-1:WordOff];
  end else begin : g_nc_slice_single
    assign w_nc_slice = '0;
  end

  // Non-cacheable beats land at their word position; cacheable beats past the line are dropped.
  assign w_wr_slice = r_nc ? w_nc_slice : r_cnt[SliceW-1:0];
  assign w_wr_en    = r_valid_i && (r_state == DATA) && (r_nc || (r_cnt < CntMax));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: if (req_valid_i)            w_state_d = ADDR;
      ADDR: if (ar_ready_i)             w_state_d = DATA;
      DATA: if (r_valid_i && r_last_i)  w_state_d = RTRN;
      RTRN:                             w_state_d = IDLE;
      default:                          w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_paddr <= '0;
      r_nc    <= 1'b0;
      r_tid   <= '0;
      r_kill  <= 1'b0;
    end else if (clr_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_paddr <= '0;
      r_nc    <= 1'b0;
      r_tid   <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (req_valid_i) begin
            r_paddr <= req_paddr_i;
            r_nc    <= req_nc_i;
            r_tid   <= req_tid_i;
          end
        end
        ADDR: begin
          if (kill_i)     r_kill <= 1'b1;
          if (ar_ready_i) r_cnt  <= '0;
        end
        DATA: begin
          if (kill_i) r_kill <= 1'b1;
          if (r_valid_i) begin
            if (w_wr_en) r_line[int'(w_wr_slice)*AxiDataWidth +: AxiDataWidth] <= r_data_i;
            if (r_cnt != CntMax) r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A kill or clear arriving in the return cycle itself still cancels the return.
  assign w_rtrn = (r_state == RTRN) && !r_kill && !kill_i && !clr_i;

  assign req_ready_o = (r_state == IDLE);
  assign ar_valid_o  = (r_state == ADDR);
  assign r_ready_o   = (r_state == DATA);
  assign busy_o      = (r_state != IDLE);
  assign ar_addr_o   = ar_valid_o ? (r_paddr & (r_nc ? WordMask : LineMask)) : '0;
  assign ar_len_o    = (ar_valid_o && !r_nc) ? LenLine : 8'd0;
  assign ar_size_o   = ar_valid_o ? SizeW : 3'd0;
  assign ar_id_o     = ar_valid_o ? ArId : '0;
  assign rtrn_vld_o  = w_rtrn;
  assign rtrn_data_o = r_line;
  assign rtrn_tid_o  = r_tid;

`ifdef ICACHE_REFILL_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (clr_i || (r_state == IDLE)) begin
      r_err <= 1'b0;
    end else if ((r_state == DATA) && r_valid_i && r_resp_i[1]) begin
      r_err <= 1'b1;
    end
  end

  assign rtrn_err_o = w_rtrn && r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^r_resp_i;
  assign rtrn_err_o    = 1'b0;
`endif

endmodule
